fetch_unit: RTL

- Instruction fetch stage. It produces the 32-bit instruction word and its PC that the instruction decoder consumes.
- It issues in-order word reads to instruction memory and buffers returned words in a small prefetch queue.
- It presents the queue head to decode with a valid/ready handshake.
- It restarts fetch at a new PC on redirect (jal/jalr/taken branch resolved downstream), discarding all stale work.

---
 rtl/cable_pkg.sv | 27 ++
 rtl/instr_fifo.sv | 49 ++++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cable_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package cable_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        FETCH_RUN   = 1'b0,
        FETCH_FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } imem_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instruction;
        logic [31:0] pc;
    } fetch_out_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with flush; combinational head, registered storage.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order imem reads feeding a prefetch queue.
module fetch_unit
    import cable_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_req_ready,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_instr_valid,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    input  logic        i_instr_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 2;

    fetch_state_e state;
    fetch_state_e state_next;
    logic [31:0]  fetch_pc;
    logic [CW:0]  drop;
    logic [CW:0]  outstanding;
    logic [SW-1:0] credit_used;
    imem_req_t    req;
    fetch_out_t   out;
    logic         fault;

    logic         accept;
    logic         rsp_take;
    logic         rsp_live;

    fetch_entry_t q_in;
    fetch_entry_t q_head;
    logic         q_pop;
    logic         q_full;
    logic         q_empty;
    logic [CW-1:0] q_count;

    logic [31:0]  p_head;
    logic         p_full;
    logic         p_empty;
    logic [CW-1:0] p_count;

    // Outstanding requests are the live ones in the PC queue plus those marked for discard.
    assign outstanding = drop + {1'b0, p_count};
    assign credit_used = SW'(q_count) + SW'(outstanding);
    assign accept      = req.valid && i_imem_req_ready;
    assign rsp_take    = i_imem_rsp_valid && (outstanding != '0);
    assign rsp_live    = rsp_take && !i_redirect && (drop == '0) && !p_empty;
    assign q_in        = {i_imem_rsp_data, p_head};
    assign q_pop       = out.valid && i_instr_ready && !i_redirect;

    instr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_prefetch_q (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (i_redirect),
        .push      (rsp_live),
        .push_data (q_in),
        .pop       (q_pop),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    instr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_pc_q (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (i_redirect),
        .push      (accept),
        .push_data (fetch_pc),
        .pop       (rsp_live),
        .head      (p_head),
        .full      (p_full),
        .empty     (p_empty),
        .count     (p_count)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= FETCH_RUN;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (i_redirect) begin
            state_next = (i_redirect_pc[1:0] != 2'b00) ? FETCH_FAULT : FETCH_RUN;
        end
    end

    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        req             = '0;
        out             = '0;
        fault           = (state == FETCH_FAULT);
        req.valid       = i_rst_n && (state == FETCH_RUN) && !i_redirect
                          && (credit_used < SW'(FIFO_DEPTH));
        req.addr        = fetch_pc;
        out.valid       = (state == FETCH_RUN) && !q_empty;
        out.instruction = out.valid ? q_head.instruction : '0;
        out.pc          = out.valid ? q_head.pc : fetch_pc;
    end

    // A redirect turns everything still in flight into responses to discard.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            fetch_pc <= RESET_PC;
            drop     <= '0;
        end else if (i_redirect) begin
            fetch_pc <= i_redirect_pc;
            drop     <= outstanding - {{CW{1'b0}}, rsp_take};
        end else begin
            if (accept)                    fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
            if (rsp_take && drop != '0)    drop     <= drop - 1'b1;
        end
    end

    assign o_imem_req_valid = req.valid;
    assign o_imem_req_addr  = req.addr;
    assign o_instr_valid    = out.valid;
    assign o_instruction    = out.instruction;
    assign o_pc             = out.pc;
    assign o_fault          = fault;

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(rsp_live && q_full && !q_pop));
    a_pcq_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(accept && p_full));
    a_rsp_expected: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_imem_rsp_valid && outstanding == '0));

endmodule
